// File: rtl/nbr_select_ctrl.sv
// nbr_select_ctrl: sequencer for the modulo address reducer in the
// neighbour-selection path. Draws a 16-bit Galois LFSR value, pulses the
// reducer's local reset, launches it, waits for its result, then fetches the
// chosen neighbour word from memory and reports it with a one-cycle done.
// Optional feature macro: NBR_SEL_TIMEOUT_EN (bounded wait on the reducer).
module nbr_select_ctrl #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          start,
    input  logic [AW-1:0] better_count,
    input  logic [AW-1:0] mem_base,
    input  logic          seed_load,
    input  logic [15:0]   seed,
    output logic          busy,
    output logic          done,
    output logic          empty,
    output logic          error,
    output logic [DW-1:0] selected,
    output logic          rng_nreset,
    output logic          rng_start,
    output logic [15:0]   rng_which,
    output logic [AW-1:0] rng_count,
    input  logic [AW-1:0] rng_address,
    input  logic          rng_done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT_RNG,
        S_FETCH,
        S_WAIT_MEM,
        S_FIN
    } state_t;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    state_t        state;
    state_t        state_nx;
    logic [15:0]   lfsr;
    logic [AW-1:0] base_q;
    logic          empty_q;
    logic          err_q;
    logic          timeout_hit;
    logic          accept;
    logic [AW-1:0] index;

    assign accept = (state == S_IDLE) && start;
    assign busy   = (state != S_IDLE);
    assign rng_start = (state == S_LAUNCH);
    assign mem_rd    = (state == S_FETCH);
    // Out-of-range reducer results fall back to the first list entry.
    assign index = (rng_address >= rng_count) ? '0 : rng_address;

`ifdef NBR_SEL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt;

    // Count cycles spent waiting on the reducer; cleared in every other state.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) tmo_cnt <= '0;
        else if (state == S_WAIT_RNG) tmo_cnt <= tmo_cnt + 1'b1;
        else tmo_cnt <= '0;
    end

    // Remember a timeout so it can be reported alongside done.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            err_q <= 1'b0;
            error <= 1'b0;
        end else begin
            if (accept) err_q <= 1'b0;
            else if (timeout_hit) err_q <= 1'b1;
            error <= (state == S_FIN) && err_q;
        end
    end
`else
    assign err_q = 1'b0;
    assign error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state <= S_IDLE;
        else state <= state_nx;
    end

    // Next-state logic; a timeout also requests a reducer reset pulse.
    always_comb begin
        state_nx    = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:     if (start) state_nx = (better_count == '0) ? S_FIN : S_CLEAR;
            S_CLEAR:    state_nx = S_LAUNCH;
            S_LAUNCH:   state_nx = S_WAIT_RNG;
            S_WAIT_RNG: begin
                if (rng_done) state_nx = S_FETCH;
`ifdef NBR_SEL_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_nx    = S_FIN;
                    timeout_hit = 1'b1;
                end
`endif
            end
            S_FETCH:    state_nx = S_WAIT_MEM;
            S_WAIT_MEM: if (mem_valid) state_nx = S_FIN;
            S_FIN:      state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Datapath registers: LFSR, latched request, reducer/memory outputs, results.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            lfsr       <= LFSR_INIT;
            base_q     <= '0;
            empty_q    <= 1'b0;
            rng_count  <= '0;
            rng_which  <= '0;
            rng_nreset <= 1'b0;
            mem_addr   <= '0;
            selected   <= '0;
            done       <= 1'b0;
            empty      <= 1'b0;
        end else begin
            // Registered so the reducer stays in reset while nreset is low.
            rng_nreset <= !((state_nx == S_CLEAR) || timeout_hit);
            if (accept) begin
                rng_count <= better_count;
                base_q    <= mem_base;
                empty_q   <= (better_count == '0);
            end
            if ((state == S_IDLE) && seed_load)
                lfsr <= (seed == 16'h0000) ? LFSR_INIT : seed;
            else if (state == S_LAUNCH)
                lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            // Loaded on entry to LAUNCH so rng_which is valid with rng_start.
            if (state == S_CLEAR) rng_which <= lfsr;
            if ((state == S_WAIT_RNG) && rng_done) mem_addr <= base_q + index;
            if ((state == S_WAIT_MEM) && mem_valid) selected <= mem_rdata;
            done  <= (state == S_FIN);
            empty <= (state == S_FIN) && empty_q;
        end
    end

endmodule

// File: tb/tb_nbr_select_ctrl.sv
// Bench for nbr_select_ctrl: behavioural reducer and memory responders,
// expected results queued at stimulus time and compared on done.
module tb_nbr_select_ctrl;

    localparam int unsigned TMO = 16;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] better_count = '0;
    logic [15:0] mem_base = '0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = '0;
    logic        busy, done, empty, error;
    logic [15:0] selected;
    logic        rng_nreset, rng_start;
    logic [15:0] rng_which, rng_count;
    logic [15:0] rng_address = '0;
    logic        rng_done = 1'b0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;

    nbr_select_ctrl #(.AW(16), .DW(16), .TIMEOUT(TMO)) dut (
        .clock(clock), .nreset(nreset), .start(start),
        .better_count(better_count), .mem_base(mem_base),
        .seed_load(seed_load), .seed(seed),
        .busy(busy), .done(done), .empty(empty), .error(error),
        .selected(selected), .rng_nreset(rng_nreset), .rng_start(rng_start),
        .rng_which(rng_which), .rng_count(rng_count),
        .rng_address(rng_address), .rng_done(rng_done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] sel;
        logic        empty;
        logic        err;
        logic        launch;
        logic [15:0] addr;
        logic [15:0] which;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [15:0] model_lfsr = 16'hACE1;
    logic [15:0] last_sel = '0;

    // Responder controls and observations.
    int          rsp_delay = 1;
    logic [15:0] rsp_addr = '0;
    int          mem_lat = 1;
    logic [15:0] mem_word = '0;
    int          rcnt = 0, mcnt = 0;
    int          rng_starts = 0, mem_rds = 0;
    logic [15:0] last_which = '0, last_rd_addr = '0;
    logic        r_st, r_nr, m_rd, m_nr;
    logic [15:0] r_w, m_a;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reducer model: latched done rsp_delay cycles after start (0 = never).
    always @(posedge clock) begin
        r_st = rng_start; r_nr = rng_nreset; r_w = rng_which;
        #1;
        if (!r_nr) begin
            rng_done = 1'b0; rcnt = 0;
        end else if (r_st) begin
            rng_starts++; last_which = r_w; rng_done = 1'b0; rcnt = rsp_delay;
        end
        if (r_nr && rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin rng_done = 1'b1; rng_address = rsp_addr; end
        end
    end

    // Memory model: one-cycle valid mem_lat cycles after the read strobe.
    always @(posedge clock) begin
        m_rd = mem_rd; m_a = mem_addr; m_nr = nreset;
        #1;
        mem_valid = 1'b0;
        if (!m_nr) mcnt = 0;
        else if (m_rd) begin mem_rds++; last_rd_addr = m_a; mcnt = mem_lat; end
        if (m_nr && mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin mem_valid = 1'b1; mem_rdata = mem_word; end
        end
    end

    task automatic test_reset();
        nreset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got %b want 0", empty); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_checks++; if (selected !== 16'h0) begin n_fail++; $display("FAIL reset_selected: got %h want 0", selected); end
        n_checks++; if (rng_nreset !== 1'b0) begin n_fail++; $display("FAIL reset_rng_nreset: got %b want 0", rng_nreset); end
        n_checks++; if (rng_start !== 1'b0) begin n_fail++; $display("FAIL reset_rng_start: got %b want 0", rng_start); end
        n_checks++; if (rng_which !== 16'h0) begin n_fail++; $display("FAIL reset_rng_which: got %h want 0", rng_which); end
        n_checks++; if (rng_count !== 16'h0) begin n_fail++; $display("FAIL reset_rng_count: got %h want 0", rng_count); end
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
        n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        nreset = 1'b1;
        @(posedge clock); #1;
        n_checks++; if (rng_nreset !== 1'b1) begin n_fail++; $display("FAIL idle_rng_nreset: got %b want 1", rng_nreset); end
        model_lfsr = 16'hACE1;
        last_sel = '0;
    endtask

    task automatic run_txn(input logic [15:0] cnt, input logic [15:0] base,
                           input logic [15:0] addr, input logic [15:0] word,
                           input int rdly, input int mlat,
                           input bit use_seed, input logic [15:0] sd,
                           input bit expect_to, input bit poke);
        exp_t e;
        int cyc, s0, r0, extra;
        bit seen;
        e.empty  = (cnt == 16'h0);
        e.launch = !e.empty;
        e.err    = expect_to;
        if (use_seed) model_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
        e.which = model_lfsr;
        if (e.launch) model_lfsr = lfsr_adv(model_lfsr);
        e.addr = base + ((addr >= cnt) ? 16'h0 : addr);
        if (e.empty) e.lat = 2;
        else if (expect_to) e.lat = 4 + TMO;
        else begin e.lat = 5 + rdly + mlat; last_sel = word; end
        e.sel = last_sel;
        sb.push_back(e);

        rsp_delay = rdly; rsp_addr = addr; mem_lat = mlat; mem_word = word;
        @(posedge clock); #1;
        better_count = cnt; mem_base = base; start = 1'b1;
        seed_load = use_seed; seed = sd;
        s0 = rng_starts; r0 = mem_rds; cyc = 0; seen = 0;
        while (!seen && cyc < 300) begin
            @(posedge clock); #1;
            start = 1'b0; seed_load = 1'b0;
            cyc++;
            if (cyc == 1) begin
                better_count = 16'hFFFF; mem_base = 16'h7777;
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
            end
            if (poke && cyc == 3) begin start = 1'b1; seed_load = 1'b1; seed = 16'h5555; end
            if (done === 1'b1) seen = 1;
        end
        e = sb.pop_front();
        n_checks++; if (!seen) begin n_fail++; $display("FAIL done_timeout: no done within %0d cycles", cyc); end
        n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL latency: got %0d want %0d", cyc, e.lat); end
        n_checks++; if (empty !== e.empty) begin n_fail++; $display("FAIL empty: got %b want %b", empty, e.empty); end
        n_checks++; if (error !== e.err) begin n_fail++; $display("FAIL error: got %b want %b", error, e.err); end
        n_checks++; if (selected !== e.sel) begin n_fail++; $display("FAIL selected: got %h want %h", selected, e.sel); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b want 0", busy); end
        n_checks++; if ((rng_starts - s0) != (e.launch ? 1 : 0)) begin n_fail++; $display("FAIL rng_start_count: got %0d want %0d", rng_starts - s0, e.launch ? 1 : 0); end
        n_checks++; if ((mem_rds - r0) != ((e.launch && !e.err) ? 1 : 0)) begin n_fail++; $display("FAIL mem_rd_count: got %0d want %0d", mem_rds - r0, (e.launch && !e.err) ? 1 : 0); end
        if (e.launch) begin
            n_checks++; if (last_which !== e.which) begin n_fail++; $display("FAIL rng_which: got %h want %h", last_which, e.which); end
            n_checks++; if (rng_count !== cnt) begin n_fail++; $display("FAIL rng_count: got %h want %h", rng_count, cnt); end
        end
        if (e.launch && !e.err) begin
            n_checks++; if (last_rd_addr !== e.addr) begin n_fail++; $display("FAIL mem_addr: got %h want %h", last_rd_addr, e.addr); end
        end
        @(posedge clock); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", done); end
        if (poke) begin
            extra = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clock); #1;
                if (done === 1'b1 || busy === 1'b1) extra++;
            end
            n_checks++; if (extra != 0) begin n_fail++; $display("FAIL start_while_busy: got %0d active cycles want 0", extra); end
        end
    endtask

    task automatic test_basic();
        run_txn(16'd3, 16'h0100, 16'd2, 16'hBEEF, 4, 1, 1'b0, 16'h0, 1'b0, 1'b0);
        run_txn(16'd9, 16'h2000, 16'd8, 16'h1234, 1, 3, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        run_txn(16'd0, 16'h0300, 16'd0, 16'hDEAD, 1, 1, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_clamp();
        run_txn(16'd3, 16'h0100, 16'd5, 16'hA5A5, 2, 1, 1'b0, 16'h0, 1'b0, 1'b0);
        run_txn(16'd3, 16'h0100, 16'd3, 16'h5A5A, 1, 2, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        run_txn(16'd4, 16'hFFFF, 16'd2, 16'hC0DE, 3, 1, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_seed();
        @(posedge clock); #1;
        seed = 16'h0000; seed_load = 1'b1;
        @(posedge clock); #1;
        seed_load = 1'b0;
        model_lfsr = 16'hACE1;
        run_txn(16'd2, 16'h0040, 16'd1, 16'h0001, 1, 1, 1'b0, 16'h0, 1'b0, 1'b0);
        run_txn(16'd2, 16'h0040, 16'd0, 16'h0002, 1, 1, 1'b0, 16'h0, 1'b0, 1'b0);
        run_txn(16'd2, 16'h0040, 16'd1, 16'h0003, 2, 2, 1'b1, 16'h1234, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn(16'd5, 16'h0500, 16'd4, 16'h4444, 2, 2, 1'b0, 16'h0, 1'b0, 1'b1);
        run_txn(16'd5, 16'h0500, 16'd1, 16'h5555, 1, 1, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

`ifdef NBR_SEL_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(16'd3, 16'h0100, 16'd1, 16'h9999, 0, 1, 1'b0, 16'h0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_abort();
        int r0, cyc, seen;
        rsp_delay = 1; rsp_addr = 16'd1; mem_lat = 40; mem_word = 16'h7E7E;
        r0 = mem_rds;
        @(posedge clock); #1;
        better_count = 16'd3; mem_base = 16'h0100; start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clock); #1;
            start = 1'b0; cyc++;
        end while (mem_rds == r0 && cyc < 50);
        n_checks++; if (mem_rds == r0) begin n_fail++; $display("FAIL abort_reach_wait_mem: no mem_rd within %0d cycles", cyc); end
        @(posedge clock); #1;
        nreset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (rng_nreset !== 1'b0) begin n_fail++; $display("FAIL abort_rng_nreset: got %b want 0", rng_nreset); end
        n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL abort_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (rng_which !== 16'h0) begin n_fail++; $display("FAIL abort_rng_which: got %h want 0", rng_which); end
        n_checks++; if (selected !== 16'h0) begin n_fail++; $display("FAIL abort_selected: got %h want 0", selected); end
        n_checks++; if (rng_count !== 16'h0) begin n_fail++; $display("FAIL abort_rng_count: got %h want 0", rng_count); end
        repeat (2) @(posedge clock);
        #1 nreset = 1'b1;
        model_lfsr = 16'hACE1;
        last_sel = '0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1 || mem_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d events want 0", seen); end
        run_txn(16'd3, 16'h0100, 16'd1, 16'h6161, 1, 1, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_clamp();
        test_wrap();
        test_seed();
        test_back_to_back();
`ifdef NBR_SEL_TIMEOUT_EN
        test_timeout();
`endif
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
